// File: rtl/pll_phase_pkg.sv
// pll_phase_pkg
// Shared types and constants for the PLL fine-phase stepper.
//   state_t      : sequencer states
//   SEL_*        : PHASESEL encodings of the EHXPLLL outputs
package pll_phase_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_LOCK,
    ST_SETUP,
    ST_PULSE_HI,
    ST_PULSE_LO,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [1:0] SEL_CLKOS  = 2'b00;
  localparam logic [1:0] SEL_CLKOS2 = 2'b01;
  localparam logic [1:0] SEL_CLKOS3 = 2'b10;
  localparam logic [1:0] SEL_CLKOP  = 2'b11;

endpackage

// File: rtl/pll_lock_filter.sv
// pll_lock_filter
// Qualifies PLL lock before phase stepping starts.
//   clk, rst   : reference clock, synchronous active-high reset
//   start      : pulse on request accept; rearms both counters
//   pll_locked : raw PLL LOCK
//   stable     : LOCK_WAIT consecutive locked cycles seen (this cycle included)
//   timeout    : LOCK_TIMEOUT cycles elapsed since start (this cycle included)
module pll_lock_filter #(
  parameter int LOCK_WAIT    = 16,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic pll_locked,
  output logic stable,
  output logic timeout
);

  localparam int LW = $clog2(LOCK_WAIT + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  logic [LW-1:0] lock_cnt;
  logic [TW-1:0] to_cnt;

  // Both are down-counters; terminal count is zero and they park there.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      lock_cnt <= LW'(LOCK_WAIT - 1);
      to_cnt   <= TW'(LOCK_TIMEOUT - 1);
    end else begin
      if (!pll_locked)
        lock_cnt <= LW'(LOCK_WAIT - 1);
      else if (lock_cnt != '0)
        lock_cnt <= lock_cnt - LW'(1);
      if (to_cnt != '0)
        to_cnt <= to_cnt - TW'(1);
    end
  end

  assign stable  = pll_locked && (lock_cnt == '0);
  assign timeout = (to_cnt == '0);

endmodule

// File: rtl/pll_phase_stepper.sv
// pll_phase_stepper
// Drives the EHXPLLL dynamic fine-phase pins from valid/ready requests and
// tracks the accumulated phase offset of each PLL output.
//   clk, rst             : reference clock, synchronous active-high reset
//   req_valid/req_ready  : request handshake (ready only while idle)
//   req_sel/dir/steps    : output select, direction (1 = decrement), step count
//   pll_locked           : PLL LOCK
//   phasesel/dir/step    : to PLL PHASESEL[1:0]/PHASEDIR/PHASESTEP
//   busy, done, err      : non-idle flag, completion pulse, abort pulse
//   phase_all            : accumulators, slice k belongs to PHASESEL encoding k
//
// state      | meaning
// IDLE       | ready for a request
// WAIT_LOCK  | qualifying PLL lock, bounded by timeout
// SETUP      | sel/dir stable ahead of the step pulse
// PULSE_HI   | phasestep high
// PULSE_LO   | phasestep low after a pulse
// DONE       | done pulse
// ERR        | err pulse (lock lost or never qualified)
module pll_phase_stepper
  import pll_phase_pkg::*;
#(
  parameter int STEP_SETUP   = 4,
  parameter int STEP_HIGH    = 4,
  parameter int STEP_LOW     = 4,
  parameter int STEPS_W      = 4,
  parameter int PH_W         = 8,
  parameter int LOCK_WAIT    = 16,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_sel,
  input  logic              req_dir,
  input  logic [STEPS_W-1:0] req_steps,
  input  logic              pll_locked,
  output logic [1:0]        phasesel,
  output logic              phasedir,
  output logic              phasestep,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [4*PH_W-1:0] phase_all
);

  localparam int TMR_W = 16;

  state_t             state;
  logic [TMR_W-1:0]   tmr;
  logic [STEPS_W-1:0] remaining;
  logic [PH_W-1:0]    acc [4];
  logic               acc_pend;
  logic               accept;
  logic               lock_stable;
  logic               lock_timeout;

  assign accept = (state == ST_IDLE) && req_valid && req_ready;

  pll_lock_filter #(
    .LOCK_WAIT   (LOCK_WAIT),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) u_lock_filter (
    .clk       (clk),
    .rst       (rst),
    .start     (accept),
    .pll_locked(pll_locked),
    .stable    (lock_stable),
    .timeout   (lock_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      phasestep <= 1'b0;
      phasesel  <= 2'b00;
      phasedir  <= 1'b0;
      remaining <= '0;
      tmr       <= '0;
      acc_pend  <= 1'b0;
      for (int k = 0; k < 4; k++) acc[k] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      // Accumulator lands one cycle after the pulse rises and is applied even
      // if that same cycle sees lock loss: an entered pulse always counts.
      if (acc_pend) begin
        acc[phasesel] <= phasedir ? acc[phasesel] - PH_W'(1) : acc[phasesel] + PH_W'(1);
        acc_pend      <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            phasesel  <= req_sel;
            phasedir  <= req_dir;
            remaining <= req_steps;
            if (req_steps == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_WAIT_LOCK;
            end
          end
        end

        ST_WAIT_LOCK: begin
          if (lock_stable) begin
            state <= ST_SETUP;
            tmr   <= TMR_W'(STEP_SETUP - 1);
          end else if (lock_timeout) begin
            state <= ST_ERR;
            err   <= 1'b1;
          end
        end

        ST_SETUP: begin
          if (!pll_locked) begin
            state <= ST_ERR;
            err   <= 1'b1;
          end else if (tmr == '0) begin
            state     <= ST_PULSE_HI;
            phasestep <= 1'b1;
            tmr       <= TMR_W'(STEP_HIGH - 1);
            remaining <= remaining - STEPS_W'(1);
            acc_pend  <= 1'b1;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end

        ST_PULSE_HI: begin
          if (!pll_locked) begin
            state     <= ST_ERR;
            err       <= 1'b1;
            phasestep <= 1'b0;
          end else if (tmr == '0) begin
            state     <= ST_PULSE_LO;
            phasestep <= 1'b0;
            tmr       <= TMR_W'(STEP_LOW - 1);
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end

        ST_PULSE_LO: begin
          if (!pll_locked) begin
            state <= ST_ERR;
            err   <= 1'b1;
          end else if (tmr == '0) begin
            if (remaining != '0) begin
              state <= ST_SETUP;
              tmr   <= TMR_W'(STEP_SETUP - 1);
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end

        ST_DONE, ST_ERR: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign phase_all = {acc[SEL_CLKOP], acc[SEL_CLKOS3], acc[SEL_CLKOS2], acc[SEL_CLKOS]};

endmodule

// File: tb/tb_pll_phase_stepper.sv
// tb_pll_phase_stepper
// Directed stimulus with a timeline model: each request's outcome (step start,
// pulse times, done/err cycle) is derived from the recorded lock history.
module tb_pll_phase_stepper;

  localparam int LOCK_WAIT    = 16;
  localparam int LOCK_TIMEOUT = 1024;
  localparam int T_SETUP      = 4;
  localparam int T_HIGH       = 4;
  localparam int T_LOW        = 4;
  localparam int PER          = T_SETUP + T_HIGH + T_LOW;
  localparam int INF          = 32'h3fff_ffff;
  localparam int HIST         = 16384;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_sel = 2'b00;
  logic        req_dir = 1'b0;
  logic [3:0]  req_steps = 4'd0;
  logic        pll_locked = 1'b0;
  logic [1:0]  phasesel;
  logic        phasedir;
  logic        phasestep;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] phase_all;

  pll_phase_stepper #(
    .STEP_SETUP(T_SETUP), .STEP_HIGH(T_HIGH), .STEP_LOW(T_LOW),
    .STEPS_W(4), .PH_W(8), .LOCK_WAIT(LOCK_WAIT), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_dir(req_dir), .req_steps(req_steps),
    .pll_locked(pll_locked), .phasesel(phasesel), .phasedir(phasedir),
    .phasestep(phasestep), .busy(busy), .done(done), .err(err),
    .phase_all(phase_all)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   rst_cyc = 0;
  bit   started = 0;
  bit   lock_hist [0:HIST-1];
  bit   active = 0;
  int   tx_t0 = 0;
  int   tx_n = 0;
  int   tx_sel = 0;
  bit   tx_dir = 0;
  logic [1:0] cur_sel = 2'b00;
  bit   cur_dir = 0;
  int   base [4] = '{0, 0, 0, 0};
  int   n_acc = 0;
  int   rise_first = -1;
  bit   ps_prev = 0;
  bit   toggle_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Outcome of the active request as known at cycle t (lock seen before t).
  function automatic void eval(input int t, output int tev, output bit is_err,
                               output bit pstep, output int cnt);
    int s_start;
    int run;
    int pp;
    tev = INF; is_err = 0; pstep = 0; cnt = 0;
    if (tx_n == 0) begin
      tev = tx_t0 + 1;
      return;
    end
    s_start = INF;
    run = 0;
    for (int c = tx_t0 + 1; c < t && s_start == INF && tev == INF; c++) begin
      run = lock_hist[c] ? run + 1 : 0;
      if (run == LOCK_WAIT) s_start = c + 1;
      else if (c == tx_t0 + LOCK_TIMEOUT) begin tev = c + 1; is_err = 1; end
    end
    if (s_start == INF) return;
    for (int c = s_start; c < t && tev == INF; c++) begin
      if (!lock_hist[c]) begin tev = c + 1; is_err = 1; end
      else if (c == s_start + tx_n * PER - 1) tev = c + 1;
    end
    for (int i = 0; i < tx_n; i++) begin
      pp = s_start + i * PER + T_SETUP;
      if (pp + 1 <= t && pp < tev) cnt++;
      if (t >= pp && t < pp + T_HIGH && t < tev) pstep = 1;
    end
  endfunction

  function automatic bit model_ready(input int t);
    int tev, cnt;
    bit e, p;
    if (t <= rst_cyc) return 0;
    if (!active || t <= tx_t0) return 1;
    eval(t, tev, e, p, cnt);
    return t > tev;
  endfunction

  // Record inputs as the DUT samples them; track accepts and resets.
  always @(posedge clk) begin : rec
    int tev, cnt;
    bit e, p;
    if (cyc < HIST) lock_hist[cyc] = pll_locked;
    if (rst) begin
      rst_cyc = cyc + 1;
      active = 0;
      for (int k = 0; k < 4; k++) base[k] = 0;
      cur_sel = 2'b00;
      cur_dir = 0;
      started = 1;
    end else if (req_valid && model_ready(cyc)) begin
      if (active) begin
        eval(cyc, tev, e, p, cnt);
        base[tx_sel] += tx_dir ? -cnt : cnt;
      end
      active = 1; tx_t0 = cyc; tx_n = int'(req_steps);
      tx_sel = int'(req_sel); tx_dir = req_dir;
      cur_sel = req_sel; cur_dir = req_dir;
      n_acc++;
    end
    cyc++;
  end

  always @(negedge clk) begin : cmp
    int tev, cnt, d;
    bit e, p;
    logic [31:0] x_pa;
    if (started) begin
      tev = INF; e = 0; p = 0; cnt = 0;
      if (active) eval(cyc, tev, e, p, cnt);
      for (int k = 0; k < 4; k++) begin
        d = base[k];
        if (active && tx_sel == k) d += tx_dir ? -cnt : cnt;
        x_pa[k*8 +: 8] = 8'(d);
      end
      chk("busy",      busy,      active && cyc > tx_t0 && cyc <= tev);
      chk("done",      done,      active && cyc == tev && !e);
      chk("err",       err,       active && cyc == tev && e);
      chk("phasestep", phasestep, active && p);
      chk("req_ready", req_ready, model_ready(cyc));
      chk("phasesel",  phasesel,  cur_sel);
      chk("phasedir",  phasedir,  cur_dir);
      chk("phase_all", phase_all, x_pa);
      if (phasestep && !ps_prev && rise_first < 0) rise_first = cyc;
      ps_prev = phasestep;
    end
  end

  task automatic send(input logic [1:0] s, input bit d, input logic [3:0] n);
    int a0, k;
    a0 = n_acc; k = 0;
    rise_first = -1;
    req_sel = s; req_dir = d; req_steps = n; req_valid = 1'b1;
    while (n_acc == a0 && k < 2000) begin @(negedge clk); k++; end
    if (n_acc == a0) chk("accept_timeout", 0, 1);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int tend, output bit was_err);
    int k;
    tend = -1; was_err = 0; k = 0;
    while (tend < 0 && k < budget) begin
      if (done || err) begin
        tend = cyc; was_err = err;
      end else begin
        @(negedge clk); #1;
        if (toggle_mode) pll_locked = ((cyc / 10) % 2) == 0;
        k++;
      end
    end
    if (tend < 0) chk("end_timeout", 0, 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t0, tend;
    bit was_err;

    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_phase_all", phase_all, 0);
    #1 rst = 0; pll_locked = 1;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);
    #1;

    // CLKOP +3 with lock stable
    send(2'b11, 0, 4'd3); t0 = tx_t0;
    wait_end(200, tend, was_err);
    chk("a_first_rise", rise_first - t0, 21);
    chk("a_done_cycle", tend - t0, 53);
    chk("a_is_done", was_err, 0);
    chk("a_clkop", phase_all[31:24], 8'd3);

    // CLKOP -5 wraps to 0xFE
    send(2'b11, 1, 4'd5); t0 = tx_t0;
    wait_end(200, tend, was_err);
    chk("b_done_cycle", tend - t0, 1 + 16 + 5 * 12);
    chk("b_phase_all", phase_all, 32'hFE00_0000);

    // zero steps
    send(2'b01, 0, 4'd0); t0 = tx_t0;
    wait_end(20, tend, was_err);
    chk("c_done_cycle", tend - t0, 1);
    chk("c_no_rise", rise_first, -1);
    chk("c_phase_all", phase_all, 32'hFE00_0000);

    // lock never asserted
    #1 pll_locked = 0;
    send(2'b00, 0, 4'd2); t0 = tx_t0;
    wait_end(1200, tend, was_err);
    chk("d_err_cycle", tend - t0, 1025);
    chk("d_is_err", was_err, 1);
    chk("d_no_rise", rise_first, -1);

    // lock toggling every 10 cycles
    @(negedge clk); #1;
    toggle_mode = 1; pll_locked = 1;
    send(2'b00, 0, 4'd2); t0 = tx_t0;
    wait_end(1200, tend, was_err);
    toggle_mode = 0;
    chk("e_err_cycle", tend - t0, 1025);
    chk("e_is_err", was_err, 1);
    chk("e_no_rise", rise_first, -1);

    // lock lost during second pulse, next request held valid
    @(negedge clk); #1 pll_locked = 1;
    send(2'b10, 0, 4'd4); t0 = tx_t0;
    req_sel = 2'b01; req_dir = 0; req_steps = 4'd1; req_valid = 1'b1;
    while (cyc < t0 + 34) @(negedge clk);
    chk("f_second_pulse", phasestep, 1);
    #1 pll_locked = 0;
    @(negedge clk);
    chk("f_err", err, 1);
    chk("f_step_low", phasestep, 0);
    chk("f_clkos3", phase_all[23:16], 8'd2);
    #1 pll_locked = 1;
    @(negedge clk);
    chk("f_ready_after_err", req_ready, 1);
    @(negedge clk);
    chk("f_next_busy", busy, 1);
    chk("f_next_sel", phasesel, 2'b01);
    #1 req_valid = 1'b0;
    wait_end(200, tend, was_err);
    chk("f_next_done", was_err, 0);
    chk("f_phase_all", phase_all, 32'hFE02_0100);

    // reset in the middle of a pulse
    @(negedge clk); #1;
    send(2'b00, 0, 4'd2);
    begin : find_pulse
      int k;
      k = 0;
      while (!phasestep && k < 100) begin @(negedge clk); k++; end
    end
    chk("g_in_pulse", phasestep, 1);
    #1 rst = 1;
    @(negedge clk);
    chk("g_step_dropped", phasestep, 0);
    chk("g_phase_all", phase_all, 0);
    chk("g_ready_in_rst", req_ready, 0);
    #1 rst = 0;
    @(negedge clk);
    chk("g_ready_back", req_ready, 1);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
